// File: rtl/stream_merge_pkg.sv
// Shared helpers for the stream merge stage and its round-robin arbiter.
package stream_merge_pkg;

  // Smallest useful number of merged ports.
  localparam int unsigned MinPorts = 2;

  // Increment an index modulo ports; wraps explicitly so non-power-of-2 counts work.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned ports);
    return ((idx + 32'd1) >= ports) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with optional packet lock; owns the pointer and lock state.
module stream_rr_arbiter
  import stream_merge_pkg::*;
#(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned LOCK_ON_LAST = 0,
  parameter int unsigned ID_WIDTH     = $clog2(PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    request,
  input  logic [PORTS-1:0]    last,
  input  logic                advance,
  output logic [PORTS-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  typedef logic [ID_WIDTH-1:0] index_t;

  index_t ptr_q;
  logic   lock_q;

  // Grant the first requester at or above the pointer, wrapping; a lock pins the pointer port.
  always_comb begin
    int unsigned k;
    grant    = '0;
    grant_id = '0;
    k        = 0;
    if (lock_q) begin
      if (request[ptr_q]) begin
        grant[ptr_q] = 1'b1;
        grant_id     = ptr_q;
      end
    end else begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        k = 32'(ptr_q) + i;
        if (k >= PORTS) k = k - PORTS;
        if ((grant == '0) && request[index_t'(k)]) begin
          grant[index_t'(k)] = 1'b1;
          grant_id           = index_t'(k);
        end
      end
    end
  end

  // Pointer and lock move only on an actual transfer, so stalls leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
    end else if (advance) begin
      if ((LOCK_ON_LAST != 0) && !last[grant_id]) begin
        lock_q <= 1'b1;
        ptr_q  <= grant_id;
      end else begin
        lock_q <= 1'b0;
        ptr_q  <= index_t'(wrap_inc(32'(grant_id), PORTS));
      end
    end
  end

endmodule

// File: rtl/stream_merge.sv
// N-to-1 stream merge: round-robin arbitration, source-id tagging, optional packet lock.
module stream_merge
  import stream_merge_pkg::*;
#(
  parameter int unsigned PORTS         = 2,
  parameter int unsigned ID_WIDTH      = $clog2(PORTS),
  parameter int unsigned PIPELINE_MODE = 1,
  parameter int unsigned LOCK_ON_LAST  = 0,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS-1:0]                  stream_in_valid,
  output logic [PORTS-1:0]                  stream_in_ready,
  input  logic [PORTS-1:0][DATA_WIDTH-1:0]  stream_in_payload,
  input  logic [PORTS-1:0]                  stream_in_last,
  output logic                              stream_out_valid,
  input  logic                              stream_out_ready,
  output logic [DATA_WIDTH-1:0]             stream_out_payload,
  output logic [ID_WIDTH-1:0]               stream_out_id
);

  typedef logic [ID_WIDTH-1:0]   index_t;
  typedef logic [DATA_WIDTH-1:0] payload_t;

  if (PORTS < MinPorts) begin : g_ports_check
    $error("stream_merge: PORTS must be greater than 1");
  end

  logic [PORTS-1:0] grant;
  index_t           grant_id;
  logic             any_grant;
  logic             enable;
  logic             advance;
  payload_t         sel_payload;

  stream_rr_arbiter #(
    .PORTS        (PORTS),
    .LOCK_ON_LAST (LOCK_ON_LAST),
    .ID_WIDTH     (ID_WIDTH)
  ) u_arbiter (
    .clk      (clk),
    .rst      (rst),
    .request  (stream_in_valid),
    .last     (stream_in_last),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign any_grant       = |grant;
  assign advance         = any_grant & enable & ~rst;
  // Only the granted port sees ready, and only when the output slot can take a beat.
  assign stream_in_ready = (enable && !rst) ? grant : '0;

  // One-hot payload select from the granted port.
  always_comb begin
    sel_payload = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (grant[k]) sel_payload = sel_payload | stream_in_payload[k];
    end
  end

  if (PIPELINE_MODE != 0) begin : g_registered
    logic     out_valid_q;
    payload_t out_payload_q;
    index_t   out_id_q;

    // Slot refills in the same cycle it drains, giving one beat per cycle.
    assign enable = ~out_valid_q | stream_out_ready;

    // Output register: payload and id travel together.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
      end else if (enable) begin
        out_valid_q <= any_grant;
        if (any_grant) begin
          out_payload_q <= sel_payload;
          out_id_q      <= grant_id;
        end
      end
    end

    assign stream_out_valid   = out_valid_q;
    assign stream_out_payload = out_payload_q;
    assign stream_out_id      = out_id_q;
  end else begin : g_passthrough
    assign enable             = stream_out_ready;
    assign stream_out_valid   = any_grant & ~rst;
    assign stream_out_payload = sel_payload;
    assign stream_out_id      = grant_id;
  end

endmodule

// File: tb/tb_stream_merge.sv
// Self-checking bench for stream_merge: reference arbiter model plus output scoreboard.
module tb_stream_merge;

  localparam int unsigned DW = 8;

  typedef struct {
    logic [DW-1:0] p;
    logic [1:0]    id;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Bench-driven stimulus, shared by both DUTs; only the selected one sees valid.
  logic [3:0]         valid;
  logic [3:0]         last;
  logic [3:0][DW-1:0] pay;
  logic               oready;
  int                 sel;

  // 4-port DUT with packet lock
  logic [3:0]         v4, r4;
  logic               ov4;
  logic [DW-1:0]      op4;
  logic [1:0]         oid4;
  // 3-port DUT without packet lock
  logic [2:0]         v3, r3;
  logic               ov3;
  logic [DW-1:0]      op3;
  logic [1:0]         oid3;

  assign v4 = (sel == 0) ? valid : 4'b0;
  assign v3 = (sel == 1) ? valid[2:0] : 3'b0;

  stream_merge #(
    .PORTS         (4),
    .ID_WIDTH      (2),
    .PIPELINE_MODE (1),
    .LOCK_ON_LAST  (1),
    .DATA_WIDTH    (DW)
  ) u_dut4 (
    .clk                (clk),
    .rst                (rst),
    .stream_in_valid    (v4),
    .stream_in_ready    (r4),
    .stream_in_payload  (pay),
    .stream_in_last     (last),
    .stream_out_valid   (ov4),
    .stream_out_ready   (oready),
    .stream_out_payload (op4),
    .stream_out_id      (oid4)
  );

  stream_merge #(
    .PORTS         (3),
    .ID_WIDTH      (2),
    .PIPELINE_MODE (1),
    .LOCK_ON_LAST  (0),
    .DATA_WIDTH    (DW)
  ) u_dut3 (
    .clk                (clk),
    .rst                (rst),
    .stream_in_valid    (v3),
    .stream_in_ready    (r3),
    .stream_in_payload  (pay[2:0]),
    .stream_in_last     (last[2:0]),
    .stream_out_valid   (ov3),
    .stream_out_ready   (oready),
    .stream_out_payload (op3),
    .stream_out_id      (oid3)
  );

  logic [3:0]    cur_rdy;
  logic          cur_ov;
  logic [DW-1:0] cur_op;
  logic [1:0]    cur_id;

  always_comb begin
    if (sel == 0) begin
      cur_rdy = r4;
      cur_ov  = ov4;
      cur_op  = op4;
      cur_id  = oid4;
    end else begin
      cur_rdy = {1'b0, r3};
      cur_ov  = ov3;
      cur_op  = op3;
      cur_id  = oid3;
    end
  end

  // Reference model state
  int       nports;
  bit       lock_en;
  int       m_ptr;
  bit       m_lock;
  bit       m_ov;
  beat_t    sb[$];
  logic [5:0] cnt[4];
  int       got_ids[$];
  int       got_pay[$];
  logic [3:0] s_rdy;
  logic       s_ov;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ids(input string tag, input int exp[$]);
    check({tag, "_count"}, got_ids.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_ids.size(); i++) begin
      check(tag, got_ids[i], exp[i]);
    end
  endtask

  // One clock: sample at negedge, compare to model, advance model, update sources after posedge.
  task automatic cycle();
    int         g;
    int         fired;
    bit         en;
    logic [3:0] exp_rdy;
    beat_t      b;
    @(negedge clk);
    g     = -1;
    fired = -1;
    en    = !m_ov || oready;
    if (!rst) begin
      if (m_lock) begin
        if (valid[m_ptr]) g = m_ptr;
      end else begin
        for (int i = 0; i < nports; i++) begin
          int k;
          k = (m_ptr + i) % nports;
          if (g < 0 && valid[k]) g = k;
        end
      end
    end
    exp_rdy = (g >= 0 && en) ? 4'(1 << g) : 4'b0;
    s_rdy   = cur_rdy;
    s_ov    = cur_ov;
    check("in_ready", cur_rdy, exp_rdy);
    check("out_valid", cur_ov, m_ov);
    if (cur_ov && oready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("out_payload", cur_op, b.p);
        check("out_id", cur_id, b.id);
      end
      got_ids.push_back(int'(cur_id));
      got_pay.push_back(int'(cur_op));
    end
    if (rst) begin
      m_ptr  = 0;
      m_lock = 0;
      m_ov   = 0;
      sb.delete();
    end else if (en) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        sb.push_back('{pay[g], 2'(g)});
        fired = g;
        if (lock_en && !last[g]) begin
          m_lock = 1;
          m_ptr  = g;
        end else begin
          m_lock = 0;
          m_ptr  = (g + 1) % nports;
        end
      end
    end
    @(posedge clk);
    #1;
    if (fired >= 0) begin
      cnt[fired]  = cnt[fired] + 6'd1;
      pay[fired]  = {2'(fired), cnt[fired]};
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    valid  = 4'b0;
    oready = 1'b1;
    run(2);
    rst = 1'b0;
    got_ids.delete();
    got_pay.delete();
  endtask

  initial begin
    sel     = 0;
    nports  = 4;
    lock_en = 1;
    m_ptr   = 0;
    m_lock  = 0;
    m_ov    = 0;
    rst     = 1'b1;
    valid   = 4'b0;
    last    = 4'hF;
    oready  = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cnt[p] = 6'd0;
      pay[p] = {2'(p), 6'd0};
    end

    // Reset state
    apply_reset();
    check("reset_out_valid", s_ov, 0);
    check("reset_ready", s_rdy, 0);

    // 1: all ports valid, output always ready
    valid = 4'hF;
    cycle();
    check("t1_first_grant", s_rdy, 4'b0001);
    check("t1_no_beat_yet", s_ov, 0);
    cycle();
    check("t1_first_beat", s_ov, 1);
    run(7);
    valid = 4'b0;
    run(2);
    check_ids("t1_ids", '{0, 1, 2, 3, 0, 1, 2, 3, 0});

    // 2: lone port 2 with A5, then lone port 1
    got_ids.delete();
    got_pay.delete();
    cnt[2] = 6'h25;
    pay[2] = {2'd2, cnt[2]};
    valid  = 4'b0100;
    cycle();
    check("t2_grant2", s_rdy, 4'b0100);
    valid = 4'b0010;
    cycle();
    check("t2_grant1", s_rdy, 4'b0010);
    valid = 4'b0;
    run(2);
    check_ids("t2_ids", '{2, 1});
    if (got_pay.size() != 0) check("t2_payload", got_pay[0], 32'hA5);

    // 3: packet lock on port 0 with a gap; port 1 must wait
    apply_reset();
    valid = 4'b0011;
    last  = 4'b1110;
    run(2);
    valid = 4'b0010;
    cycle();
    check("t3_bubble_ready", s_rdy, 4'b0000);
    valid = 4'b0011;
    last  = 4'b1111;
    cycle();
    valid = 4'b0010;
    cycle();
    valid = 4'b0;
    run(2);
    check_ids("t3_ids", '{0, 0, 0, 1});

    // 4: output ready toggling
    apply_reset();
    valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      oready = (i % 2 == 0);
      cycle();
    end
    valid  = 4'b0;
    oready = 1'b1;
    run(3);
    check_ids("t4_ids", '{0, 1, 2, 3, 0, 1});

    // 5: reset while locked on port 3
    apply_reset();
    valid = 4'b1000;
    last  = 4'b0111;
    cycle();
    rst   = 1'b1;
    valid = 4'hF;
    last  = 4'hF;
    cycle();
    check("t5_rst_ready", s_rdy, 4'b0000);
    cycle();
    check("t5_rst_out_valid", s_ov, 0);
    check("t5_rst_ready_held", s_rdy, 4'b0000);
    rst = 1'b0;
    got_ids.delete();
    got_pay.delete();
    run(3);
    valid = 4'b0;
    run(2);
    check_ids("t5_ids", '{0, 1, 2});

    // 6: three ports, valid on 2 and 0 only
    sel     = 1;
    nports  = 3;
    lock_en = 0;
    apply_reset();
    valid = 4'b0100;
    cycle();
    valid = 4'b0101;
    run(4);
    valid = 4'b0;
    run(2);
    check_ids("t6_ids", '{2, 0, 2, 0, 2});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
